debounce3: RTL and testbench
============================

Name: debounce3

Overview:
- Three-channel push-button conditioner that drives the inputs of the 3-input XOR gate stage on the IceZUM board.
- Per channel: synchronises the raw pin into clk, filters contact bounce with a stability counter, and emits a clean level plus one-cycle rise/fall pulses.
- Outputs x_out[0..2] connect directly to gate inputs x0, x1, x2.

Parameters:
- N_CH, 3, number of independent channels.
- STABLE_CYCLES, 12000, consecutive cycles of a stable synchronised level needed to accept a change (1 ms at 12 MHz); legal range 1..2^CNT_W.
- CNT_W, 14, stability counter width; must satisfy STABLE_CYCLES-1 < 2^CNT_W.
- INVERT, 3'b000, per-channel mask; 1 = pin is active-low, inverted before synchronisation.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_in  input  N_CH  raw asynchronous button pins.
- x_out  output  N_CH  debounced level per channel.
- rise  output  N_CH  one-cycle pulse when x_out goes 0->1.
- fall  output  N_CH  one-cycle pulse when x_out goes 1->0.

Behaviour:
- Reset (rst=1 at a clk edge), all channels:
  - sync flops = 0, counter = 0, x_out = 0, rise = 0, fall = 0.
  - rst overrides all other activity, including an in-progress count.
- Input conditioning: b = btn_in ^ INVERT, passed through a 2-flop synchroniser to give s (2 cycles latency).
- Per-channel state is the stable level x_out plus the counter cnt. Each edge:
  - s == x_out: cnt <= 0; x_out holds.
  - s != x_out and cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - s != x_out and cnt == STABLE_CYCLES-1: x_out <= s; cnt <= 0.
- Latency: a clean step on btn_in appears on x_out exactly STABLE_CYCLES+2 edges later.
- Glitch rejection: any excursion of s shorter than STABLE_CYCLES cycles:
  - clears cnt when s returns;
  - never changes x_out;
  - never pulses rise/fall.
- The counter restarts from 0 on every bounce. There is no hysteresis memory beyond cnt.
- Edge pulses:
  - rise and fall are registered.
  - They assert in the same cycle x_out first shows its new value, for exactly one cycle.
  - rise and fall are never both high on the same channel.
- Channels are fully independent. Simultaneous transitions on several channels each produce their own pulse in the same cycle.
- STABLE_CYCLES == 1: x_out follows s with one extra cycle of latency (3 edges total).
- Pin held active through reset release: after reset x_out = 0, so the channel counts from 0 and x_out rises STABLE_CYCLES+2 edges after rst deasserts, with a rise pulse.
- The counter never wraps: it is bounded by STABLE_CYCLES-1.

Decomposition:
- Shared package (board constants):
  - CLK_HZ = 12_000_000.
  - DEBOUNCE_MS = 1.
  - Derived STABLE_CYCLES default.
  - CNT_W computed as clog2(STABLE_CYCLES).
- Sub-module debounce_ch holds one channel: synchroniser, counter, level and pulse registers.
  - debounce3 instantiates it N_CH times via generate and slices INVERT per channel.

Test Plan (sim with STABLE_CYCLES=8, CNT_W=3):
- Reset: rst=1 for 3 cycles with btn_in=3'b111 -> x_out=0, rise=0, fall=0 during reset; after release x_out=3'b111 at edge 10 after deassert, rise=3'b111 for exactly that one cycle.
- Clean press: btn_in[0] 0->1 held -> x_out[0]=1 exactly 10 edges later, rise[0] high one cycle, fall=0, channels 1-2 unchanged.
- Bounce: btn_in[1] toggles 1,0,1,0 with 3-cycle periods, then holds 1 -> no pulse during bouncing; x_out[1]=1 at 10 edges after the final 0->1; single rise[1].
- Glitch: btn_in[2] high for 7 cycles then low -> x_out[2] stays 0, rise/fall stay 0.
- INVERT=3'b010, btn_in[1] held 0 from reset -> x_out[1]=1 after 10 edges; release btn_in[1]=1 -> fall[1] pulse, x_out[1]=0 10 edges later.
- Reset mid-count: btn_in[0]=1 for 5 cycles, then rst=1 for 1 cycle, then btn_in stays 1 -> x_out[0] rises 10 edges after rst deasserts, not earlier.

Source files
------------

// File: rtl/debounce3_pkg.sv
// Board-level constants for the IceZUM button conditioner.
// Debounce window and counter width come from the 12 MHz system clock.
package debounce3_pkg;

    localparam int CLK_HZ      = 12_000_000;
    localparam int DEBOUNCE_MS = 1;

    localparam int STABLE_CYCLES_DEF = (CLK_HZ / 1000) * DEBOUNCE_MS;

    // The counter only has to reach cycles-1, so clog2(cycles) bits suffice; never drop below 1 bit
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    localparam int CNT_W_DEF = cnt_width(STABLE_CYCLES_DEF);

endpackage

// File: rtl/debounce_ch.sv
// One button channel: optional inversion, 2-flop synchroniser, stability counter,
// accepted level, and registered one-cycle rise/fall pulses.
module debounce_ch
    import debounce3_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int CNT_W         = cnt_width(STABLE_CYCLES),
    parameter bit INVERT        = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;
    logic             pin;

    assign pin = btn ^ INVERT;

    // Any return of the synchronised level to the accepted one restarts the count,
    // so only a run of STABLE_CYCLES identical samples can move the level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], pin};
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync[1];
                cnt   <= '0;
                rise  <= sync[1];
                fall  <= ~sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/debounce3.sv
// Three independent debounced button channels feeding the x0..x2 inputs
// of the XOR gate stage.
module debounce3
    import debounce3_pkg::*;
#(
    parameter int              N_CH          = 3,
    parameter int              STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int              CNT_W         = CNT_W_DEF,
    parameter logic [N_CH-1:0] INVERT        = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] x_out,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W),
            .INVERT        (INVERT[i])
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .btn   (btn_in[i]),
            .level (x_out[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

endmodule

// File: tb/tb_debounce3.sv
// Directed bench for debounce3 with an 8-cycle window: per-cycle expectations
// are queued as stimulus is applied and popped after each clock edge.
module tb_debounce3;

    typedef struct {
        string      tag;
        bit         use_b;
        logic [2:0] x;
        logic [2:0] r;
        logic [2:0] f;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] btn_a = 3'b000;
    logic [2:0] btn_b = 3'b000;
    logic [2:0] x_a, rise_a, fall_a;
    logic [2:0] x_b, rise_b, fall_b;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    debounce3 #(.N_CH(3), .STABLE_CYCLES(8), .CNT_W(3), .INVERT(3'b000)) dut_a (
        .clk    (clk),
        .rst    (rst),
        .btn_in (btn_a),
        .x_out  (x_a),
        .rise   (rise_a),
        .fall   (fall_a)
    );

    // Second instance exercises the active-low pin mask on channel 1
    debounce3 #(.N_CH(3), .STABLE_CYCLES(8), .CNT_W(3), .INVERT(3'b010)) dut_b (
        .clk    (clk),
        .rst    (rst),
        .btn_in (btn_b),
        .x_out  (x_b),
        .rise   (rise_b),
        .fall   (fall_b)
    );

    task automatic checkOutput();
        exp_t       e;
        logic [2:0] ox, orr, of;
        total++;
        assert (sb.size() > 0) else begin
            bad++;
            $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e   = sb.pop_front();
        ox  = e.use_b ? x_b    : x_a;
        orr = e.use_b ? rise_b : rise_a;
        of  = e.use_b ? fall_b : fall_a;
        total++;
        assert (ox === e.x) else begin
            bad++;
            $error("[TB] FAIL %s.x_out observed=%b expected=%b", e.tag, ox, e.x);
        end
        total++;
        assert (orr === e.r) else begin
            bad++;
            $error("[TB] FAIL %s.rise observed=%b expected=%b", e.tag, orr, e.r);
        end
        total++;
        assert (of === e.f) else begin
            bad++;
            $error("[TB] FAIL %s.fall observed=%b expected=%b", e.tag, of, e.f);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic r, input logic [2:0] b,
                                 input bit use_b, input logic [2:0] ex,
                                 input logic [2:0] er, input logic [2:0] ef);
        exp_t e;
        @(negedge clk);
        rst = r;
        if (use_b) btn_b = b;
        else       btn_a = b;
        e.tag   = tag;
        e.use_b = use_b;
        e.x     = ex;
        e.r     = er;
        e.f     = ef;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic holdCycles(input string tag, input logic r, input logic [2:0] b,
                              input bit use_b, input int n, input logic [2:0] ex);
        for (int i = 0; i < n; i++) applyStimulus(tag, r, b, use_b, ex, 3'b000, 3'b000);
    endtask

    initial begin
        $display("[TB] start");

        // Reset with all pins pressed, then the level appears 10 edges after release
        holdCycles("rst_hold", 1'b1, 3'b111, 1'b0, 3, 3'b000);
        holdCycles("rst_wait", 1'b0, 3'b111, 1'b0, 9, 3'b000);
        applyStimulus("rst_rise", 1'b0, 3'b111, 1'b0, 3'b111, 3'b111, 3'b000);
        holdCycles("rst_after", 1'b0, 3'b111, 1'b0, 2, 3'b111);

        // Simultaneous release on all channels
        holdCycles("clr_wait", 1'b0, 3'b000, 1'b0, 9, 3'b111);
        applyStimulus("clr_fall", 1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 3'b111);
        holdCycles("clr_after", 1'b0, 3'b000, 1'b0, 2, 3'b000);

        // Clean press on channel 0
        holdCycles("press_wait", 1'b0, 3'b001, 1'b0, 9, 3'b000);
        applyStimulus("press_rise", 1'b0, 3'b001, 1'b0, 3'b001, 3'b001, 3'b000);
        holdCycles("press_after", 1'b0, 3'b001, 1'b0, 2, 3'b001);

        // Bouncing channel 1, then a steady press
        for (int k = 0; k < 2; k++) begin
            holdCycles("bounce_hi", 1'b0, 3'b011, 1'b0, 3, 3'b001);
            holdCycles("bounce_lo", 1'b0, 3'b001, 1'b0, 3, 3'b001);
        end
        holdCycles("bounce_wait", 1'b0, 3'b011, 1'b0, 9, 3'b001);
        applyStimulus("bounce_rise", 1'b0, 3'b011, 1'b0, 3'b011, 3'b010, 3'b000);
        holdCycles("bounce_after", 1'b0, 3'b011, 1'b0, 2, 3'b011);

        // Longest rejectable glitch on channel 2
        holdCycles("glitch_hi", 1'b0, 3'b111, 1'b0, 7, 3'b011);
        holdCycles("glitch_lo", 1'b0, 3'b011, 1'b0, 12, 3'b011);

        holdCycles("rel_wait", 1'b0, 3'b000, 1'b0, 9, 3'b011);
        applyStimulus("rel_fall", 1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 3'b011);
        holdCycles("rel_after", 1'b0, 3'b000, 1'b0, 2, 3'b000);

        // Reset in the middle of a count restarts the full window
        holdCycles("mid_count", 1'b0, 3'b001, 1'b0, 5, 3'b000);
        applyStimulus("mid_rst", 1'b1, 3'b001, 1'b0, 3'b000, 3'b000, 3'b000);
        holdCycles("mid_wait", 1'b0, 3'b001, 1'b0, 9, 3'b000);
        applyStimulus("mid_rise", 1'b0, 3'b001, 1'b0, 3'b001, 3'b001, 3'b000);
        holdCycles("mid_after", 1'b0, 3'b001, 1'b0, 2, 3'b001);

        // Active-low channel 1: pin low through reset reads as pressed
        holdCycles("inv_rst", 1'b1, 3'b000, 1'b1, 2, 3'b000);
        holdCycles("inv_wait", 1'b0, 3'b000, 1'b1, 9, 3'b000);
        applyStimulus("inv_rise", 1'b0, 3'b000, 1'b1, 3'b010, 3'b010, 3'b000);
        holdCycles("inv_after", 1'b0, 3'b000, 1'b1, 2, 3'b010);
        holdCycles("inv_rel_wait", 1'b0, 3'b010, 1'b1, 9, 3'b010);
        applyStimulus("inv_fall", 1'b0, 3'b010, 1'b1, 3'b000, 3'b000, 3'b010);
        holdCycles("inv_rel_after", 1'b0, 3'b010, 1'b1, 2, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
